signal_multi_phase: RTL and testbench
=====================================

SIGNAL_MULTI_PHASE -- requirements
Module: signal_multi_phase

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-002 Parameters SHALL be, as name, default, meaning:
- NBITS, 32, dwell counter width.
- NPHASE, 4, number of signal phases (approaches), 2..16.
- GREEN_CYC, 150000000, green dwell in clk cycles.
- YELLOW_CYC, 50000000, yellow dwell in clk cycles.
- ALLRED_CYC, 25000000, all-red clearance dwell in clk cycles.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- req, in, NPHASE, per-phase demand (level, sampled).
- go, out, NPHASE, green per phase.
- warn, out, NPHASE, yellow per phase.
- stop, out, NPHASE, red per phase.
- phase, out, PW=max(1,clog2(NPHASE)), index of the current/last served phase.
- green_start, out, 1, one-cycle pulse on the first green cycle.

Function
REQ-004 All outputs SHALL be registered, and stop SHALL equal ~(go|warn) in every cycle.
REQ-005 At most one bit of go|warn SHALL be set in any cycle.
REQ-006 The FSM SHALL have states CLEAR (all red), GREEN and YELLOW, with transitions CLEAR->GREEN->YELLOW->CLEAR.
REQ-007 The dwell counter SHALL load (duration-1) on state entry, decrement by 1 per cycle, and the state SHALL advance in the cycle after the counter reads 0.
- Dwell per state is exactly GREEN_CYC, YELLOW_CYC or ALLRED_CYC cycles.
REQ-008 In GREEN, go[phase]=1; in YELLOW, warn[phase]=1; in CLEAR, go=warn=0.
REQ-009 On the CLEAR->GREEN transition, phase SHALL update to the next phase.
- If any req bit is set, next phase = first set bit scanning round-robin from phase+1 mod NPHASE, wrapping back to phase itself.
- If no req bit is set, next phase = phase+1 mod NPHASE (fixed-time mode).
REQ-010 req SHALL be sampled only in the last CLEAR cycle; changes at any other time SHALL have no effect.
REQ-011 The phase index SHALL wrap from NPHASE-1 to 0.
REQ-012 green_start SHALL be 1 exactly in the first GREEN cycle of each service and 0 otherwise.
REQ-013 Durations SHALL be >=1 and <2^NBITS.
- Any duration of 0 SHALL be treated as 1 (clamped at elaboration).

Reset
REQ-014 While reset=1 at a clk edge, the block SHALL enter CLEAR with the counter loaded to ALLRED_CYC-1 and phase=NPHASE-1.
- Outputs: go=0, warn=0, stop=all ones, green_start=0.
REQ-015 Reset asserted in any state, mid-dwell, SHALL take effect at the next edge with no partial yellow.
- Green SHALL drop directly to all red.
REQ-016 After reset release with req=0, the first GREEN SHALL be phase 0 after exactly ALLRED_CYC cycles of CLEAR.

Verification (NPHASE=3, GREEN_CYC=4, YELLOW_CYC=2, ALLRED_CYC=1, NBITS=8)
REQ-017 Release reset with req=0 -> go=001 for 4 cycles, warn=001 for 2, all red 1, then go=010.
- green_start pulses at each go rising edge.
- Sequence continues 100, 001, ...
REQ-018 req=100 held from reset -> every green serves phase 2 only, with the 4/2/1 cadence repeating.
REQ-019 phase=0 in GREEN, req=011 asserted before the last CLEAR cycle -> next green is phase 1, the following is phase 0, and phase 2 is skipped.
REQ-020 reset pulsed for 1 cycle during the 3rd GREEN cycle of phase 1 -> next cycle stop=111, go=warn=0, then go=001 after 1 CLEAR cycle.
REQ-021 Every cycle of all runs -> check stop==~(go|warn) and popcount(go|warn)<=1.
- req toggled outside the last CLEAR cycle does not alter the phase order.

Source files
------------

// File: rtl/signal_multi_phase.sv
// Multi-phase traffic signal controller: round-robin service of NPHASE approaches
// through an all-red / green / yellow cycle with per-state dwell counters.
module signal_multi_phase #(
  parameter int NBITS      = 32,
  parameter int NPHASE     = 4,
  parameter int GREEN_CYC  = 150000000,
  parameter int YELLOW_CYC = 50000000,
  parameter int ALLRED_CYC = 25000000,
  parameter int PW         = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NPHASE-1:0] req,
  output logic [NPHASE-1:0] go,
  output logic [NPHASE-1:0] warn,
  output logic [NPHASE-1:0] stop,
  output logic [PW-1:0]     phase,
  output logic              green_start
);

  // Zero durations collapse to a single cycle so every state is always visited.
  localparam int unsigned GREEN_EFF  = (GREEN_CYC  < 1) ? 1 : GREEN_CYC;
  localparam int unsigned YELLOW_EFF = (YELLOW_CYC < 1) ? 1 : YELLOW_CYC;
  localparam int unsigned ALLRED_EFF = (ALLRED_CYC < 1) ? 1 : ALLRED_CYC;

  localparam logic [NBITS-1:0] GREEN_LOAD  = NBITS'(GREEN_EFF - 1);
  localparam logic [NBITS-1:0] YELLOW_LOAD = NBITS'(YELLOW_EFF - 1);
  localparam logic [NBITS-1:0] ALLRED_LOAD = NBITS'(ALLRED_EFF - 1);
  localparam logic [PW-1:0]    LAST_PHASE  = PW'(NPHASE - 1);

  typedef enum logic [1:0] {
    CLEAR,
    GREEN,
    YELLOW
  } state_t;

  state_t            state_q, state_d;
  logic [NBITS-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [NPHASE-1:0] go_q, go_d;
  logic [NPHASE-1:0] warn_q, warn_d;
  logic [NPHASE-1:0] stop_q, stop_d;
  logic              green_start_q, green_start_d;

  // Round-robin search starting after cur; with no demand it simply steps forward.
  function automatic logic [PW-1:0] pick_next(input logic [PW-1:0]     cur,
                                              input logic [NPHASE-1:0] dem);
    logic [PW-1:0] nxt;
    logic          found;
    int            idx;
    idx   = (int'(cur) + 1) % NPHASE;
    nxt   = PW'(idx);
    found = 1'b0;
    for (int i = 1; i <= NPHASE; i++) begin
      idx = (int'(cur) + i) % NPHASE;
      if (!found && dem[PW'(idx)]) begin
        nxt   = PW'(idx);
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CLEAR;
      cnt_q         <= ALLRED_LOAD;
      phase_q       <= LAST_PHASE;
      go_q          <= '0;
      warn_q        <= '0;
      stop_q        <= '1;
      green_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      go_q          <= go_d;
      warn_q        <= warn_d;
      stop_q        <= stop_d;
      green_start_q <= green_start_d;
    end
  end

  // req only matters on the last all-red cycle, where the next phase is chosen.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 1'b1;
    phase_d = phase_q;
    if (cnt_q == '0) begin
      unique case (state_q)
        CLEAR: begin
          state_d = GREEN;
          cnt_d   = GREEN_LOAD;
          phase_d = pick_next(phase_q, req);
        end
        GREEN: begin
          state_d = YELLOW;
          cnt_d   = YELLOW_LOAD;
        end
        YELLOW: begin
          state_d = CLEAR;
          cnt_d   = ALLRED_LOAD;
        end
        default: begin
          state_d = CLEAR;
          cnt_d   = ALLRED_LOAD;
        end
      endcase
    end
  end

  // Lamp outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    go_d          = '0;
    warn_d        = '0;
    if (state_d == GREEN)  go_d[phase_d]   = 1'b1;
    if (state_d == YELLOW) warn_d[phase_d] = 1'b1;
    stop_d        = ~(go_d | warn_d);
    green_start_d = (state_d == GREEN) && (state_q != GREEN);
  end

  assign go          = go_q;
  assign warn        = warn_q;
  assign stop        = stop_q;
  assign phase       = phase_q;
  assign green_start = green_start_q;

endmodule

// File: tb/tb_signal_multi_phase.sv
// Scoreboard bench for signal_multi_phase: a time-slot reference model predicts
// every cycle's lamps, phase and green_start; a monitor compares them.
module tb_signal_multi_phase;

  localparam int NBITS  = 8;
  localparam int NPHASE = 3;
  localparam int G      = 4;
  localparam int Y      = 2;
  localparam int A      = 1;
  localparam int PW     = 2;
  localparam int PERIOD = A + G + Y;

  logic              clk;
  logic              reset;
  logic [NPHASE-1:0] req;
  logic [NPHASE-1:0] go;
  logic [NPHASE-1:0] warn;
  logic [NPHASE-1:0] stop;
  logic [PW-1:0]     phase;
  logic              green_start;

  typedef struct packed {
    logic [NPHASE-1:0] go;
    logic [NPHASE-1:0] warn;
    logic [NPHASE-1:0] stop;
    logic [PW-1:0]     phase;
    logic              gs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_p     = 0;
  int   m_phase = NPHASE - 1;

  signal_multi_phase #(
    .NBITS(NBITS), .NPHASE(NPHASE), .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(A)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .go(go), .warn(warn), .stop(stop),
    .phase(phase), .green_start(green_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next served approach: first demanding one after cur, cur itself last; none -> cur+1.
  function automatic int rr_next(input int cur, input logic [NPHASE-1:0] r);
    int cand;
    if (r == '0) return (cur + 1) % NPHASE;
    for (int k = 1; k <= NPHASE; k++) begin
      cand = (cur + k) % NPHASE;
      if (r[cand]) return cand;
    end
    return (cur + 1) % NPHASE;
  endfunction

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req_v, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge, queue the prediction.
  task automatic apply_stimulus(input logic rst, input logic [NPHASE-1:0] r);
    exp_t e;
    reset = rst;
    req   = r;
    if (rst) begin
      m_p     = 0;
      m_phase = NPHASE - 1;
    end else begin
      if (m_p == A - 1) m_phase = rr_next(m_phase, r);
      m_p = (m_p + 1) % PERIOD;
    end
    e.go    = '0;
    e.warn  = '0;
    e.stop  = '1;
    if (m_p >= A && m_p < A + G) begin
      e.go[m_phase]   = 1'b1;
      e.stop[m_phase] = 1'b0;
    end else if (m_p >= A + G) begin
      e.warn[m_phase] = 1'b1;
      e.stop[m_phase] = 1'b0;
    end
    e.phase = PW'(m_phase);
    e.gs    = (m_p == A);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_idle(input int n, input logic [NPHASE-1:0] r);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, r);
  endtask

  // Advance with req=0 until the model shows the given phase at the given slot, within a budget.
  task automatic seek(input int ph, input int slot, input string name);
    int budget;
    budget = 40;
    while (!(m_phase == ph && m_p == slot) && budget > 0) begin
      apply_stimulus(1'b0, '0);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("[TB] FAIL %s: slot not reached, got budget %0d, expected >0", name, budget);
    end
  endtask

  // Monitor: every cycle presents a full set of registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (stop !== ~(go | warn)) begin
        errors++;
        $display("[TB] FAIL stop_inv: got %0h, expected %0h", stop, ~(go | warn));
      end
      checks++;
      if ($countones(go | warn) > 1) begin
        errors++;
        $display("[TB] FAIL onehot: got %0d lit, expected <=1", $countones(go | warn));
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("go",          16'(go),          16'(e.go));
        check_output("warn",        16'(warn),        16'(e.warn));
        check_output("stop",        16'(stop),        16'(e.stop));
        check_output("phase",       16'(phase),       16'(e.phase));
        check_output("green_start", 16'(green_start), 16'(e.gs));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, '0);
    // Fixed-time rotation 0,1,2,0...
    run_idle(25, '0);
    // Demand only on approach 2 from reset.
    apply_stimulus(1'b1, 3'b100);
    apply_stimulus(1'b1, 3'b100);
    run_idle(25, 3'b100);
    // Demand on 0 and 1 raised while phase 0 is green: 1 then 0, skipping 2.
    apply_stimulus(1'b1, '0);
    seek(0, A, "seek_p0_green");
    run_idle(16, 3'b011);
    run_idle(8, '0);
    // Reset during third green cycle of phase 1.
    seek(1, A + 2, "seek_p1_g3");
    apply_stimulus(1'b1, '0);
    run_idle(12, '0);
    // Random demand with rare resets.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(0, 63) == 0), NPHASE'($urandom_range(0, 7)));
    end
    run_idle(2, '0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
